// File: rtl/tpu_pe.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pe
// Purpose  : Weight-stationary processing element for the tiny-TPU systolic
//            array. Signed fixed-point (default Q8.8). A shadow weight
//            register loads from the north while the active weight feeds the
//            multiply-accumulate. Activations flow west->east, weights and
//            partial sums flow north->south.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            pe_enabled          - PE enable; low clears all state
//            pe_valid_in/out     - activation valid (west in / east out)
//            pe_input_in/out     - activation (west in / east out)
//            pe_accept_w_in      - load pe_weight_in into the shadow weight
//            pe_weight_in/out    - weight (north in / south out)
//            pe_switch_in        - copy shadow weight into active weight
//            pe_psum_in/out      - partial sum (north in / south out)
// Revision : 1.0 - initial release
// ============================================================================
module tpu_pe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_valid_in,
  input  logic              pe_accept_w_in,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic [DATA_W-1:0] pe_psum_in,
  input  logic              pe_switch_in,
  input  logic              pe_enabled,
  output logic              pe_valid_out,
  output logic [DATA_W-1:0] pe_input_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic [DATA_W-1:0] pe_psum_out
);

  localparam int c_PROD_W = 2 * DATA_W;
  // One guard bit above the product is enough to hold psum + rounded product.
  localparam int c_SUM_W  = c_PROD_W + 1;

  localparam logic signed [c_PROD_W-1:0] c_RND     = c_PROD_W'(1) << (FRAC_W - 1);
  localparam logic signed [c_SUM_W-1:0]  c_SAT_MAX = c_SUM_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [c_SUM_W-1:0]  c_SAT_MIN = c_SUM_W'(-(1 << (DATA_W - 1)));

  // Weight buffers (names are probed hierarchically).
  logic [DATA_W-1:0] weight_reg_inactive;
  logic [DATA_W-1:0] weight_reg_active;

  logic [DATA_W-1:0] inactive_d;
  logic [DATA_W-1:0] active_d;
  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] input_q,  input_d;
  logic [DATA_W-1:0] weight_q, weight_d;
  logic [DATA_W-1:0] psum_q,   psum_d;

  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [c_PROD_W-1:0] w_prod_rnd;
  logic signed [c_SUM_W-1:0]  w_sum;
  logic [DATA_W-1:0]          w_sat;

  // MAC datapath uses the registered activation and the pre-edge active weight.
  always_comb begin
    w_prod     = $signed(input_q) * $signed(weight_reg_active);
    // Round to nearest, ties toward +inf, then arithmetic shift.
    w_prod_rnd = (w_prod + c_RND) >>> FRAC_W;
    w_sum      = c_SUM_W'($signed(pe_psum_in)) + c_SUM_W'(w_prod_rnd);
    if (w_sum > c_SAT_MAX) begin
      w_sat = c_SAT_MAX[DATA_W-1:0];
    end else if (w_sum < c_SAT_MIN) begin
      w_sat = c_SAT_MIN[DATA_W-1:0];
    end else begin
      w_sat = w_sum[DATA_W-1:0];
    end
  end

  always_comb begin
    inactive_d = weight_reg_inactive;
    active_d   = weight_reg_active;
    valid_d    = pe_valid_in;
    input_d    = '0;
    weight_d   = '0;
    psum_d     = '0;

    if (pe_accept_w_in) begin
      inactive_d = pe_weight_in;
      weight_d   = pe_weight_in;
    end
    // Old shadow value moves to active even when a new weight loads this edge.
    if (pe_switch_in) begin
      active_d = weight_reg_inactive;
    end
    if (pe_valid_in) begin
      input_d = pe_input_in;
    end
    if (valid_q) begin
      psum_d = w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !pe_enabled) begin
      weight_reg_inactive <= '0;
      weight_reg_active   <= '0;
      valid_q             <= 1'b0;
      input_q             <= '0;
      weight_q            <= '0;
      psum_q              <= '0;
    end else begin
      weight_reg_inactive <= inactive_d;
      weight_reg_active   <= active_d;
      valid_q             <= valid_d;
      input_q             <= input_d;
      weight_q            <= weight_d;
      psum_q              <= psum_d;
    end
  end

  assign pe_valid_out  = valid_q;
  assign pe_input_out  = input_q;
  assign pe_weight_out = weight_q;
  assign pe_psum_out   = psum_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_pe
// Purpose  : Directed self-checking bench for tpu_pe (Q8.8 fixed point).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_pe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pe_valid_in = 1'b0;
  logic        pe_accept_w_in = 1'b0;
  logic [15:0] pe_input_in = '0;
  logic [15:0] pe_weight_in = '0;
  logic [15:0] pe_psum_in = '0;
  logic        pe_switch_in = 1'b0;
  logic        pe_enabled = 1'b1;
  logic        pe_valid_out;
  logic [15:0] pe_input_out;
  logic [15:0] pe_weight_out;
  logic [15:0] pe_psum_out;

  int n_checks = 0;
  int n_err    = 0;

  tpu_pe #(.DATA_W(16), .FRAC_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .pe_valid_in    (pe_valid_in),
    .pe_accept_w_in (pe_accept_w_in),
    .pe_input_in    (pe_input_in),
    .pe_weight_in   (pe_weight_in),
    .pe_psum_in     (pe_psum_in),
    .pe_switch_in   (pe_switch_in),
    .pe_enabled     (pe_enabled),
    .pe_valid_out   (pe_valid_out),
    .pe_input_out   (pe_input_out),
    .pe_weight_out  (pe_weight_out),
    .pe_psum_out    (pe_psum_out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inact"}, dut.weight_reg_inactive, 16'h0000);
    chk({tag, "_act"},   dut.weight_reg_active,   16'h0000);
    chk({tag, "_vout"},  {15'd0, pe_valid_out},   16'h0000);
    chk({tag, "_iout"},  pe_input_out,            16'h0000);
    chk({tag, "_wout"},  pe_weight_out,           16'h0000);
    chk({tag, "_psum"},  pe_psum_out,             16'h0000);
  endtask

  initial begin
    // Reset edge with a weight load pending: reset wins.
    rst = 1'b1; pe_accept_w_in = 1'b1; pe_weight_in = 16'h0459;  // 4.34765625
    step();
    chk_all_zero("reset");

    rst = 1'b0;
    step();
    chk("t1_inact", dut.weight_reg_inactive, 16'h0459);
    chk("t1_wout",  pe_weight_out,           16'h0459);
    chk("t1_act",   dut.weight_reg_active,   16'h0000);

    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0A9A;  // 10.6015625
    pe_valid_in = 1'b1; pe_input_in = 16'h0200;      // 2.0
    pe_switch_in = 1'b1; pe_psum_in = 16'h0000;
    step();
    chk("t2_inact", dut.weight_reg_inactive, 16'h0A9A);
    chk("t2_act",   dut.weight_reg_active,   16'h0459);
    chk("t2_wout",  pe_weight_out,           16'h0A9A);
    chk("t2_iout",  pe_input_out,            16'h0200);
    chk("t2_vout",  {15'd0, pe_valid_out},   16'h0001);
    chk("t2_psum",  pe_psum_out,             16'h0000);

    pe_weight_in = 16'h05C0;                         // 5.75
    pe_input_in  = 16'hFC9A;                         // -3.3984375
    step();
    chk("t3_inact", dut.weight_reg_inactive, 16'h05C0);
    chk("t3_act",   dut.weight_reg_active,   16'h0A9A);
    chk("t3_psum",  pe_psum_out,             16'h08B2);  // 2.0*4.34765625
    chk("t3_iout",  pe_input_out,            16'hFC9A);

    pe_accept_w_in = 1'b0; pe_weight_in = 16'h1234;
    pe_input_in = 16'h135C;                          // 19.359375
    step();
    chk("t4_inact", dut.weight_reg_inactive, 16'h05C0);
    chk("t4_act",   dut.weight_reg_active,   16'h05C0);
    chk("t4_wout",  pe_weight_out,           16'h0000);
    chk("t4_psum",  pe_psum_out,             16'hDBF9);  // -36.02734375
    chk("t4_iout",  pe_input_out,            16'h135C);

    // Valid drops: last MAC still emerges, input_out zeroes.
    pe_switch_in = 1'b0; pe_valid_in = 1'b0; pe_input_in = 16'h7777;
    step();
    chk("t5_psum",  pe_psum_out,             16'h6F51);  // 19.359375*5.75
    chk("t5_iout",  pe_input_out,            16'h0000);
    chk("t5_vout",  {15'd0, pe_valid_out},   16'h0000);

    step();
    chk("t6_psum_idle", pe_psum_out, 16'h0000);

    // Saturation: active weight 127.0.
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h7F00;
    step();
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1;
    pe_valid_in = 1'b1; pe_input_in = 16'h7F00;      // 127.0
    step();
    chk("sat_act", dut.weight_reg_active, 16'h7F00);
    pe_switch_in = 1'b0; pe_input_in = 16'h8100;     // -127.0
    pe_psum_in = 16'h6400;                           // 100.0
    step();
    chk("sat_pos", pe_psum_out, 16'h7FFF);
    pe_valid_in = 1'b0;
    step();
    chk("sat_neg", pe_psum_out, 16'h8000);

    // Disable mid-stream clears everything in one edge.
    pe_valid_in = 1'b1; pe_input_in = 16'h0100; pe_accept_w_in = 1'b1;
    pe_weight_in = 16'h0300; pe_enabled = 1'b0;
    step();
    chk_all_zero("dis");

    // Resume; rounding ties at +/-0.5 LSB.
    pe_enabled = 1'b1; pe_accept_w_in = 1'b1; pe_weight_in = 16'h0080;  // 0.5
    pe_valid_in = 1'b0; pe_psum_in = 16'h0005;
    step();
    chk("res_inact", dut.weight_reg_inactive, 16'h0080);
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1;
    pe_valid_in = 1'b1; pe_input_in = 16'h0001;
    step();
    pe_switch_in = 1'b0; pe_input_in = 16'hFFFF;
    step();
    chk("tie_pos", pe_psum_out, 16'h0006);  // 5 + round(0.5) = 6
    pe_valid_in = 1'b0;
    step();
    chk("tie_neg", pe_psum_out, 16'h0005);  // 5 + round(-0.5) = 5

    // Reset mid-stream.
    pe_valid_in = 1'b1; pe_input_in = 16'h0400; pe_accept_w_in = 1'b1;
    pe_weight_in = 16'h0200; rst = 1'b1;
    step();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    step();
    chk("post_rst_iout",  pe_input_out,            16'h0400);
    chk("post_rst_inact", dut.weight_reg_inactive, 16'h0200);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
